timer_irq_unit: RTL and testbench

- Memory-mapped countdown timer on the CPU's peripheral bus (bridge side).
- Raises the hardware interrupt line consumed by the coprocessor-0 interrupt logic as one bit of HWInt[5:0].
- Software programs PRESET and CTRL, then reads COUNT back.
- Supports a one-shot mode and an auto-reload mode.

---
 rtl/timer_irq_pkg.sv | 31 +++
 rtl/timer_irq_if.sv | 12 +
 rtl/timer_prescaler.sv | 27 ++
 rtl/timer_irq_unit.sv | 164 ++++++++++++++++
 tb/tb_timer_irq_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_irq_pkg.sv
// Shared constants for timer_irq_unit: FSM state codes, register map, CTRL fields and MODE codes.
package timer_irq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_CNT  = 2'd2;
  localparam state_t ST_INT  = 2'd3;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_LSB  = 1;
  localparam int CTRL_MODE_W    = 2;
  localparam int CTRL_IM_BIT    = 3;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_W   = 8;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Codes 10/11 are not auto-reload, so they fall back to one-shot behaviour.
  function automatic logic is_auto_mode(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/timer_irq_if.sv
// Peripheral-bus view of the timer: CPU bridge drives the strobe/address/data, timer returns read data and status.
interface timer_irq_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        busy;

  modport master (output we, addr, wdata, input rdata, irq, busy);
  modport slave  (input we, addr, wdata, output rdata, irq, busy);
endinterface

// File: rtl/timer_prescaler.sv
// Tick generator for the countdown: one tick every presc+1 cycles while run is high.
module timer_prescaler #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          run,
  input  logic [PW-1:0] presc,
  output logic          tick
);

  logic [PW-1:0] pcnt;

  assign tick = run && (pcnt == presc);

  // Held at zero while the timer reloads so every period starts with a full prescale interval.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pcnt <= '0;
    else if (clr)
      pcnt <= '0;
    else if (run)
      pcnt <= tick ? '0 : pcnt + PW'(1);
  end

endmodule

// File: rtl/timer_irq_unit.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes driving one HWInt line.
// Build option: define TIMER_PRESCALE_EN to add the CTRL[15:8] PRESC field and the tick prescaler.
module timer_irq_unit
  import timer_irq_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RELOAD_GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  timer_irq_if.slave  bus
);

  localparam logic [1:0] GAP_LAST = 2'(RELOAD_GAP - 1);
  localparam logic [1:0] GAP_CLR  = 2'(RELOAD_GAP - 2);

  state_t           state;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [1:0]       gap_cnt;
  logic             irq_flag;
  logic             ctrl_en;
  logic [1:0]       ctrl_mode;
  logic             ctrl_im;
  logic             tick;
  logic             ctrl_wr;
  logic             preset_wr;
  logic             enter_int;
  logic             auto_clr;

`ifdef TIMER_PRESCALE_EN
  logic [CTRL_PRESC_W-1:0] ctrl_presc;

  timer_prescaler #(.PW(CTRL_PRESC_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_LOAD),
    .run   (state == ST_CNT),
    .presc (ctrl_presc),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
  assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);
  assign enter_int = (state == ST_CNT) && ctrl_en && tick && (count <= CNT_W'(1));

  // In auto-reload the flag lives RELOAD_GAP cycles from INT entry; with a gap of 1 that is just the INT cycle.
  assign auto_clr = is_auto_mode(ctrl_mode) &&
                    (((RELOAD_GAP == 1) && (state == ST_INT)) ||
                     ((RELOAD_GAP > 1) && (state == ST_LOAD) && (gap_cnt == GAP_CLR)));

  // A CPU write to CTRL always beats the hardware EN clear issued from INT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      ctrl_presc <= '0;
`endif
    end else if (ctrl_wr) begin
      ctrl_en   <= bus.wdata[CTRL_EN_BIT];
      ctrl_mode <= bus.wdata[CTRL_MODE_LSB +: CTRL_MODE_W];
      ctrl_im   <= bus.wdata[CTRL_IM_BIT];
`ifdef TIMER_PRESCALE_EN
      ctrl_presc <= bus.wdata[CTRL_PRESC_LSB +: CTRL_PRESC_W];
`endif
    end else if ((state == ST_INT) && !is_auto_mode(ctrl_mode)) begin
      ctrl_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      preset <= '0;
    else if (preset_wr)
      preset <= bus.wdata[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_en) begin
            state   <= ST_LOAD;
            gap_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (!ctrl_en) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            count <= preset;
            if (gap_cnt == GAP_LAST) begin
              state   <= ST_CNT;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 2'd1;
            end
          end
        end
        ST_CNT: begin
          // A count of 0 or 1 ends the period, so a zero preset behaves like a preset of one.
          if (!ctrl_en) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (count > CNT_W'(1)) begin
              count <= count - CNT_W'(1);
            end else begin
              count <= '0;
              state <= ST_INT;
            end
          end
        end
        ST_INT: begin
          state   <= is_auto_mode(ctrl_mode) ? ST_LOAD : ST_IDLE;
          gap_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The hardware set wins over a CTRL write landing while the timer sits in INT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      irq_flag <= 1'b0;
    else if (enter_int)
      irq_flag <= 1'b1;
    else if (auto_clr)
      irq_flag <= 1'b0;
    else if (ctrl_wr && (state != ST_INT))
      irq_flag <= 1'b0;
  end

  assign bus.irq  = irq_flag & ctrl_im;
  assign bus.busy = (state == ST_LOAD) || (state == ST_CNT);

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_CTRL: begin
        bus.rdata[CTRL_EN_BIT]                    = ctrl_en;
        bus.rdata[CTRL_MODE_LSB +: CTRL_MODE_W]   = ctrl_mode;
        bus.rdata[CTRL_IM_BIT]                    = ctrl_im;
`ifdef TIMER_PRESCALE_EN
        bus.rdata[CTRL_PRESC_LSB +: CTRL_PRESC_W] = ctrl_presc;
`endif
      end
      ADDR_PRESET: bus.rdata = 32'(preset);
      ADDR_COUNT:  bus.rdata = 32'(count);
      default:     bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_unit.sv
// Directed-vector bench for timer_irq_unit: register table plus hand sequences for multi-cycle corners.
module tb_timer_irq_unit;

  localparam int GAP = 1;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    logic        exp_busy;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vectors;
  int   n_miscompares;
  vec_t vecs[$];

  timer_irq_if bus ();

  timer_irq_unit #(.CNT_W(32), .RELOAD_GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add_vec(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] r, input logic i, input logic b);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d;
    v.exp_rdata = r; v.exp_irq = i; v.exp_busy = b;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    bit found;
    n_vectors     = 0;
    n_miscompares = 0;
    reset     = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 32'd0;

    // Reset values, ignored writes, then one-shot PRESET=5 with IM.
    add_vec(0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0);
    add_vec(0, 2, 0, 0, 0, 0);
    add_vec(0, 3, 0, 0, 0, 0);
    add_vec(1, 3, 32'hFFFF_FFFF, 0, 0, 0);
    add_vec(1, 2, 32'h0000_1234, 0, 0, 0);
    add_vec(1, 1, 5, 5, 0, 0);
    add_vec(1, 0, 32'h0000_00F9, 32'h9, 0, 0);
    add_vec(0, 2, 0, 0, 0, 1);
    add_vec(0, 2, 0, 5, 0, 1);
    add_vec(0, 2, 0, 4, 0, 1);
    add_vec(0, 2, 0, 3, 0, 1);
    add_vec(0, 2, 0, 2, 0, 1);
    add_vec(0, 2, 0, 1, 0, 1);
    add_vec(0, 2, 0, 0, 1, 0);
    add_vec(0, 0, 0, 32'h8, 1, 0);
    add_vec(0, 2, 0, 0, 1, 0);
    add_vec(0, 0, 0, 32'h8, 1, 0);
    add_vec(1, 0, 0, 0, 0, 0);
    // Auto-reload PRESET=3, then PRESET=6 written mid-count.
    add_vec(1, 1, 3, 3, 0, 0);
    add_vec(1, 0, 32'hB, 32'hB, 0, 0);
    add_vec(0, 2, 0, 0, 0, 1);
    add_vec(0, 2, 0, 3, 0, 1);
    add_vec(0, 2, 0, 2, 0, 1);
    add_vec(0, 2, 0, 1, 0, 1);
    add_vec(0, 2, 0, 0, 1, 0);
    add_vec(0, 2, 0, 0, 0, 1);
    add_vec(0, 2, 0, 3, 0, 1);
    add_vec(1, 1, 6, 6, 0, 1);
    add_vec(0, 2, 0, 1, 0, 1);
    add_vec(0, 2, 0, 0, 1, 0);
    add_vec(0, 2, 0, 0, 0, 1);
    add_vec(0, 2, 0, 6, 0, 1);
    add_vec(0, 2, 0, 5, 0, 1);
    add_vec(0, 2, 0, 4, 0, 1);
    add_vec(0, 2, 0, 3, 0, 1);
    add_vec(0, 2, 0, 2, 0, 1);
    add_vec(0, 2, 0, 1, 0, 1);
    add_vec(0, 2, 0, 0, 1, 0);
    add_vec(0, 2, 0, 0, 0, 1);
    add_vec(0, 2, 0, 6, 0, 1);
    add_vec(1, 0, 0, 0, 0, 1);
    add_vec(0, 2, 0, 5, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_irq", i), 32'(bus.irq), 32'(vecs[i].exp_irq));
      checkOutput($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
    end

    // PRESC field write: only retained when the prescaler is built in.
    applyStimulus(1, 0, 32'h0000_FF00);
`ifdef TIMER_PRESCALE_EN
    checkOutput("presc_field", bus.rdata, 32'h0000_FF00);
`else
    checkOutput("presc_field", bus.rdata, 32'h0);
`endif
    applyStimulus(1, 0, 0);

    // Masked one-shot: EN clears, irq never rises, later CTRL write leaves it low.
    applyStimulus(1, 1, 2);
    applyStimulus(1, 0, 32'h1);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("masked_irq_c%0d", c), 32'(bus.irq), 0);
    end
    checkOutput("masked_en_cleared", bus.rdata, 32'h0);
    applyStimulus(1, 0, 32'h8);
    checkOutput("masked_ctrl8_irq", 32'(bus.irq), 0);
    applyStimulus(0, 0, 0);
    checkOutput("masked_ctrl8_rd", bus.rdata, 32'h8);
    checkOutput("masked_ctrl8_irq2", 32'(bus.irq), 0);
    applyStimulus(1, 0, 0);

    // Clear EN while COUNT reaches 7, then re-enable.
    applyStimulus(1, 1, 10);
    applyStimulus(1, 0, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus(0, 2, 0);
      if (bus.rdata == 32'd8) found = 1'b1;
    end
    checkOutput("poll_count8", 32'(found), 1);
    applyStimulus(1, 0, 0);
    checkOutput("clr_en_busy_same", 32'(bus.busy), 1);
    applyStimulus(0, 2, 0);
    checkOutput("clr_en_count", bus.rdata, 7);
    checkOutput("clr_en_idle", 32'(bus.busy), 0);
    applyStimulus(0, 2, 0);
    checkOutput("clr_en_hold", bus.rdata, 7);
    applyStimulus(1, 0, 32'h1);
    applyStimulus(0, 2, 0);
    checkOutput("reen_load_busy", 32'(bus.busy), 1);
    applyStimulus(0, 2, 0);
    checkOutput("reen_reload", bus.rdata, 10);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 2, 0);

    // Auto-reload over four periods: irq high one cycle out of every 3+GAP+1.
    applyStimulus(1, 1, 3);
    applyStimulus(1, 0, 32'hB);
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(0, 2, 0);
      checkOutput($sformatf("auto_irq_c%0d", c), 32'(bus.irq),
                  32'((c % (3 + GAP + 1)) == 0));
    end
    applyStimulus(1, 0, 0);
    applyStimulus(0, 2, 0);

    // CPU CTRL write landing in INT: write wins, flag still sets; then async reset mid-CNT.
    applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 32'h9);
    applyStimulus(0, 2, 0);
    applyStimulus(0, 2, 0);
    applyStimulus(0, 2, 0);
    checkOutput("race_int_irq", 32'(bus.irq), 1);
    applyStimulus(1, 0, 32'h9);
    checkOutput("race_cpu_wins", bus.rdata, 32'h9);
    checkOutput("race_flag_kept", 32'(bus.irq), 1);
    applyStimulus(1, 1, 4);
    checkOutput("race_reload_busy", 32'(bus.busy), 1);
    applyStimulus(0, 2, 0);
    checkOutput("race_cnt_count", bus.rdata, 4);
    checkOutput("race_cnt_irq", 32'(bus.irq), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_irq", 32'(bus.irq), 0);
    checkOutput("async_rst_busy", 32'(bus.busy), 0);
    bus.addr = 2'd0;
    #1;
    checkOutput("async_rst_ctrl", bus.rdata, 0);
    bus.addr = 2'd1;
    #1;
    checkOutput("async_rst_preset", bus.rdata, 0);
    bus.addr = 2'd2;
    #1;
    checkOutput("async_rst_count", bus.rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("post_rst_ctrl", bus.rdata, 0);
    checkOutput("post_rst_busy", 32'(bus.busy), 0);

`ifdef TIMER_PRESCALE_EN
    // PRESC=3, PRESET=2: two ticks of four cycles each before INT.
    applyStimulus(1, 1, 2);
    applyStimulus(1, 0, 32'h309);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(0, 2, 0);
      checkOutput($sformatf("presc_irq_c%0d", c), 32'(bus.irq), 32'(c == 10));
    end
    applyStimulus(1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
